// File: rtl/izh_neuron_scheduler.sv
// Izhikevich neuron scheduler: sweeps N virtual neurons through one shared
// update datapath per tick, holding per-neuron v/u/current and a spike vector.

// Per-neuron storage: v, u, input current and this sweep's spike bit.
module izh_neuron_slot #(
  parameter int                        STATE_W = 16,
  parameter int                        I_W     = 8,
  parameter logic signed [STATE_W-1:0] V_INIT  = -16'sd1040,
  parameter logic signed [STATE_W-1:0] U_INIT  = -16'sd208
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [I_W-1:0]     i_cfg_data,
  input  logic               i_wb_en,
  input  logic [STATE_W-1:0] i_v_next,
  input  logic [STATE_W-1:0] i_u_next,
  input  logic               i_spike,
  input  logic               i_spk_clr,
  output logic [STATE_W-1:0] o_v,
  output logic [STATE_W-1:0] o_u,
  output logic [I_W-1:0]     o_i,
  output logic               o_spike
);
  logic [STATE_W-1:0] r_v, r_u;
  logic [I_W-1:0]     r_i;
  logic               r_spike;

  // State writeback from the datapath, spike clear at sweep start, current config.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v     <= V_INIT;
      r_u     <= U_INIT;
      r_i     <= '0;
      r_spike <= 1'b0;
    end else begin
      if (i_wb_en) begin
        r_v     <= i_v_next;
        r_u     <= i_u_next;
        r_spike <= i_spike;
      end else if (i_spk_clr) begin
        r_spike <= 1'b0;
      end
      if (i_cfg_we) r_i <= i_cfg_data;
    end
  end

  assign o_v     = r_v;
  assign o_u     = r_u;
  assign o_i     = r_i;
  assign o_spike = r_spike;
endmodule

module izh_neuron_scheduler #(
  parameter int                        N_NEURONS = 4,
  parameter int                        STATE_W   = 16,
  parameter int                        I_W       = 8,
  parameter logic signed [STATE_W-1:0] V_INIT    = -16'sd1040,
  parameter logic signed [STATE_W-1:0] U_INIT    = -16'sd208
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] i_cfg_addr,
  input  logic [I_W-1:0]       i_cfg_data,
  output logic                 o_dp_valid,
  input  logic                 i_dp_ready,
  output logic [STATE_W-1:0]   o_dp_v,
  output logic [STATE_W-1:0]   o_dp_u,
  output logic [I_W-1:0]       o_dp_i,
  input  logic                 i_dp_res_valid,
  input  logic [STATE_W-1:0]   i_dp_v_next,
  input  logic [STATE_W-1:0]   i_dp_u_next,
  input  logic                 i_dp_spike,
  output logic [N_NEURONS-1:0] o_spike_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overrun
);
  localparam int IDX_W = $clog2(N_NEURONS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                              r_state;
  logic [IDX_W-1:0]                    r_idx;
  logic                                r_dp_valid, r_busy, r_done, r_overrun;
  logic [STATE_W-1:0]                  r_dp_v, r_dp_u;
  logic [I_W-1:0]                      r_dp_i;
  logic [N_NEURONS-1:0]                r_spike_out;

  logic [N_NEURONS-1:0][STATE_W-1:0]   w_v, w_u;
  logic [N_NEURONS-1:0][I_W-1:0]       w_i;
  logic [N_NEURONS-1:0]                w_shadow, w_spike_fin;
  logic                                w_start, w_wb, w_last;
  logic [IDX_W-1:0]                    w_idx_nxt;

  assign w_start   = (r_state == S_IDLE) && i_tick;
  assign w_wb      = (r_state == S_WAIT) && i_dp_res_valid;
  assign w_last    = (r_idx == IDX_W'(N_NEURONS-1));
  assign w_idx_nxt = r_idx + 1'b1;

  genvar k;
  generate
    for (k = 0; k < N_NEURONS; k++) begin : g_slot
      izh_neuron_slot #(
        .STATE_W (STATE_W),
        .I_W     (I_W),
        .V_INIT  (V_INIT),
        .U_INIT  (U_INIT)
      ) u_slot (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cfg_we   (i_cfg_we && (i_cfg_addr == IDX_W'(k))),
        .i_cfg_data (i_cfg_data),
        .i_wb_en    (w_wb && (r_idx == IDX_W'(k))),
        .i_v_next   (i_dp_v_next),
        .i_u_next   (i_dp_u_next),
        .i_spike    (i_dp_spike),
        .i_spk_clr  (w_start),
        .o_v        (w_v[k]),
        .o_u        (w_u[k]),
        .o_i        (w_i[k]),
        .o_spike    (w_shadow[k])
      );
    end
  endgenerate

  // Final spike vector merges the last neuron's result, which lands on the same edge.
  always_comb begin
    w_spike_fin        = w_shadow;
    w_spike_fin[r_idx] = i_dp_spike;
  end

  // Sweep FSM; payload is latched from slot outputs before any same-edge config write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_v      <= '0;
      r_dp_u      <= '0;
      r_dp_i      <= '0;
      r_spike_out <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_tick) begin
            r_state    <= S_ISSUE;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_dp_valid <= 1'b1;
            r_dp_v     <= w_v[0];
            r_dp_u     <= w_u[0];
            r_dp_i     <= w_i[0];
          end
        end
        S_ISSUE: begin
          if (i_dp_ready) begin
            r_dp_valid <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_dp_res_valid) begin
            if (w_last) begin
              r_state     <= S_DONE;
              r_spike_out <= w_spike_fin;
              r_done      <= 1'b1;
            end else begin
              r_idx      <= w_idx_nxt;
              r_state    <= S_ISSUE;
              r_dp_valid <= 1'b1;
              r_dp_v     <= w_v[w_idx_nxt];
              r_dp_u     <= w_u[w_idx_nxt];
              r_dp_i     <= w_i[w_idx_nxt];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dp_valid  = r_dp_valid;
  assign o_dp_v      = r_dp_v;
  assign o_dp_u      = r_dp_u;
  assign o_dp_i      = r_dp_i;
  assign o_spike_out = r_spike_out;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Bench for izh_neuron_scheduler: plays the datapath, tracks neuron state in
// plain arrays and checks issued payloads, spike vectors and status outputs.
module tb_izh_neuron_scheduler;
  localparam int N = 4;
  localparam logic [15:0] V_INIT = -16'sd1040;
  localparam logic [15:0] U_INIT = -16'sd208;

  logic        clk = 1'b0;
  logic        rst, tick, cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        dp_valid, dp_ready;
  logic [15:0] dp_v, dp_u;
  logic [7:0]  dp_i;
  logic        dp_res_valid;
  logic [15:0] dp_v_next, dp_u_next;
  logic        dp_spike;
  logic [3:0]  spike_out;
  logic        busy, done, overrun;

  logic [15:0] m_v [N];
  logic [15:0] m_u [N];
  logic [7:0]  m_i [N];
  logic        m_ovr;
  logic [3:0]  m_spk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  izh_neuron_scheduler #(.N_NEURONS(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_cfg_we(cfg_we),
    .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_dp_valid(dp_valid), .i_dp_ready(dp_ready),
    .o_dp_v(dp_v), .o_dp_u(dp_u), .o_dp_i(dp_i),
    .i_dp_res_valid(dp_res_valid), .i_dp_v_next(dp_v_next),
    .i_dp_u_next(dp_u_next), .i_dp_spike(dp_spike),
    .o_spike_out(spike_out), .o_busy(busy), .o_done(done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; dp_ready = 1'b0; dp_res_valid = 1'b0;
    step; step;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_v[k] = V_INIT; m_u[k] = U_INIT; m_i[k] = 8'd0;
    end
    m_ovr = 1'b0;
    m_spk = 4'b0;
  endtask

  // One full sweep with the bench acting as datapath.
  // tick_mode: 0 none, 1 extra tick during neuron 1 WAIT, 2 tick in DONE cycle.
  // abort_k: assert reset during WAIT of that neuron (-1: never).
  task automatic do_sweep(input int stall_k, input int stall_n, input int lat_max,
                          input bit rnd, input logic [3:0] spk_pat,
                          input int cfg_k, input logic [7:0] cfg_val,
                          input int tick_mode, input bit spurious, input int abort_k);
    int t0, lat;
    logic [3:0]  exp_spk;
    logic [15:0] nv, nu;
    logic        ns;
    exp_spk = 4'b0;
    tick = 1'b1;
    t0 = cyc;
    if (cfg_k == 0) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = cfg_val; end
    step;
    tick = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_total++;
      if (dp_valid !== 1'b1 || busy !== 1'b1 || dp_v !== m_v[k] || dp_u !== m_u[k] || dp_i !== m_i[k])
        $display("FAIL issue n%0d: valid=%b busy=%b v=%h u=%h i=%h, expected 1 1 %h %h %h",
                 k, dp_valid, busy, dp_v, dp_u, dp_i, m_v[k], m_u[k], m_i[k]);
      else n_pass++;
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          dp_ready = 1'b0;
          step;
          n_total++;
          if (dp_valid !== 1'b1 || dp_v !== m_v[k] || dp_u !== m_u[k] || dp_i !== m_i[k])
            $display("FAIL stall n%0d c%0d: valid=%b v=%h u=%h i=%h, expected 1 %h %h %h",
                     k, s, dp_valid, dp_v, dp_u, dp_i, m_v[k], m_u[k], m_i[k]);
          else n_pass++;
        end
      end
      if (cfg_k == k) m_i[k] = cfg_val;
      dp_ready = 1'b1;
      if (spurious) begin
        dp_res_valid = 1'b1; dp_v_next = 16'($urandom); dp_u_next = 16'($urandom); dp_spike = 1'b1;
      end
      step;
      dp_ready = 1'b0; dp_res_valid = 1'b0;
      n_total++;
      if (dp_valid !== 1'b0) $display("FAIL wait_valid n%0d: valid=%b, expected 0", k, dp_valid);
      else n_pass++;
      if (k == abort_k) begin
        rst = 1'b1;
        step;
        rst = 1'b0;
        n_total++;
        if (dp_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || done !== 1'b0 || spike_out !== 4'b0)
          $display("FAIL abort: valid=%b busy=%b ovr=%b done=%b spk=%b, expected 0 0 0 0 0000",
                   dp_valid, busy, overrun, done, spike_out);
        else n_pass++;
        for (int j = 0; j < N; j++) begin
          m_v[j] = V_INIT; m_u[j] = U_INIT; m_i[j] = 8'd0;
        end
        m_ovr = 1'b0; m_spk = 4'b0;
        return;
      end
      lat = int'($urandom_range(1, lat_max));
      for (int j = 1; j < lat; j++) step;
      if (rnd) begin
        nv = 16'($urandom); nu = 16'($urandom); ns = 1'($urandom);
      end else begin
        nv = m_v[k] + 16'd1; nu = m_u[k] + 16'd1; ns = spk_pat[k];
      end
      dp_res_valid = 1'b1; dp_v_next = nv; dp_u_next = nu; dp_spike = ns;
      if (cfg_k == k + 1) begin cfg_we = 1'b1; cfg_addr = 2'(k + 1); cfg_data = cfg_val; end
      if (tick_mode == 1 && k == 1) begin tick = 1'b1; m_ovr = 1'b1; end
      step;
      dp_res_valid = 1'b0; cfg_we = 1'b0; tick = 1'b0;
      m_v[k] = nv; m_u[k] = nu; exp_spk[k] = ns;
    end
    n_total++;
    if (done !== 1'b1 || busy !== 1'b1 || spike_out !== exp_spk)
      $display("FAIL done_cycle: done=%b busy=%b spk=%b, expected 1 1 %b", done, busy, spike_out, exp_spk);
    else n_pass++;
    if (stall_n == 0 && lat_max == 1) begin
      n_total++;
      if (cyc - t0 !== 2 * N + 1) $display("FAIL latency: done at tick+%0d, expected tick+%0d", cyc - t0, 2 * N + 1);
      else n_pass++;
    end
    m_spk = exp_spk;
    if (tick_mode == 2) begin tick = 1'b1; m_ovr = 1'b1; end
    step;
    tick = 1'b0;
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || dp_valid !== 1'b0 || spike_out !== m_spk || overrun !== m_ovr)
      $display("FAIL after_done: done=%b busy=%b valid=%b spk=%b ovr=%b, expected 0 0 0 %b %b",
               done, busy, dp_valid, spike_out, overrun, m_spk, m_ovr);
    else n_pass++;
  endtask

  task automatic test_reset;
    do_reset;
    n_total++;
    if (dp_valid !== 1'b0 || dp_v !== 16'd0 || dp_u !== 16'd0 || dp_i !== 8'd0)
      $display("FAIL reset_dp: valid=%b v=%h u=%h i=%h, expected 0 0 0 0", dp_valid, dp_v, dp_u, dp_i);
    else n_pass++;
    n_total++;
    if (spike_out !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_status: spk=%b busy=%b done=%b ovr=%b, expected 0000 0 0 0", spike_out, busy, done, overrun);
    else n_pass++;
  endtask

  task automatic test_basic_sweep;
    do_sweep(-1, 0, 1, 1'b0, 4'b0000, -1, 8'd0, 0, 1'b0, -1);
  endtask

  task automatic test_spikes;
    do_sweep(-1, 0, 1, 1'b0, 4'b1010, -1, 8'd0, 0, 1'b0, -1);
    do_sweep(-1, 0, 1, 1'b0, 4'b0000, -1, 8'd0, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure;
    do_sweep(2, 5, 1, 1'b0, 4'b0100, -1, 8'd0, 0, 1'b0, -1);
  endtask

  task automatic test_cfg;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd10;
    step;
    cfg_we = 1'b0;
    m_i[0] = 8'd10;
    do_sweep(-1, 0, 1, 1'b0, 4'b0000, 1, 8'd20, 0, 1'b0, -1);
    do_sweep(-1, 0, 2, 1'b0, 4'b0001, -1, 8'd0, 0, 1'b0, -1);
  endtask

  task automatic test_overrun;
    do_sweep(-1, 0, 1, 1'b0, 4'b0000, -1, 8'd0, 2, 1'b0, -1);
    do_reset;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: ovr=%b, expected 0", overrun);
    else n_pass++;
    do_sweep(-1, 0, 1, 1'b0, 4'b0110, -1, 8'd0, 1, 1'b1, -1);
    do_sweep(-1, 0, 1, 1'b0, 4'b0000, -1, 8'd0, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    do_sweep(-1, 0, 1, 1'b1, 4'b0, -1, 8'd0, 0, 1'b0, -1);
    do_sweep(-1, 0, 1, 1'b1, 4'b0, -1, 8'd0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_midsweep;
    do_sweep(-1, 0, 1, 1'b0, 4'b0000, -1, 8'd0, 0, 1'b0, 2);
    do_sweep(-1, 0, 1, 1'b0, 4'b0000, -1, 8'd0, 0, 1'b0, -1);
  endtask

  task automatic test_random;
    int ck;
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        cfg_we = 1'b1; cfg_addr = 2'($urandom); cfg_data = 8'($urandom);
        step;
        cfg_we = 1'b0;
        m_i[cfg_addr] = cfg_data;
      end
      ck = int'($urandom_range(0, 4)) - 1;
      do_sweep(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3, 1'b1, 4'b0,
               ck, 8'($urandom), 0, 1'($urandom), -1);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
    dp_ready = 1'b0; dp_res_valid = 1'b0; dp_v_next = 16'd0; dp_u_next = 16'd0; dp_spike = 1'b0;
    test_reset;
    test_basic_sweep;
    test_spikes;
    test_backpressure;
    test_cfg;
    test_back_to_back;
    test_overrun;
    test_reset_midsweep;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
